// File: rtl/out_queue_if.sv
// Interface for the out_queue stage: CPU write strobe and data, plus the
// drain-side valid/ready handshake and status. The queue takes the slave
// modport; the CPU/consumer side takes the master modport.
// Optional macro OUTQ_DROPCNT_EN adds the drop_count status signal.
interface out_queue_if #(
    parameter int AW = 2
);
    logic          doOut;
    logic [7:0]    dbus;
    logic [7:0]    out_data;
    logic          out_valid;
    logic          out_ready;
    logic          full;
    logic [AW:0]   count;
    logic          overflow;
`ifdef OUTQ_DROPCNT_EN
    logic [7:0]    drop_count;
`endif

`ifdef OUTQ_DROPCNT_EN
    modport slave  (input  doOut, dbus, out_ready,
                    output out_data, out_valid, full, count, overflow, drop_count);
    modport master (output doOut, dbus, out_ready,
                    input  out_data, out_valid, full, count, overflow, drop_count);
`else
    modport slave  (input  doOut, dbus, out_ready,
                    output out_data, out_valid, full, count, overflow);
    modport master (output doOut, dbus, out_ready,
                    input  out_data, out_valid, full, count, overflow);
`endif
endinterface

// File: rtl/out_queue.sv
// out_queue: first-word-fall-through byte FIFO buffering CPU output
// instruction writes for a slow external consumer. Writes into a full queue
// are dropped and flagged by the sticky overflow bit.
// Optional macro OUTQ_DROPCNT_EN adds a saturating dropped-write counter.
module out_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic        clk,
    input  logic        reset,
    out_queue_if.slave  q
);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW:0]   count_q;
    logic          overflow_q;
    logic          rd;
    logic          wr_ok;
    logic          drop;

    // Status and handshake decode, all from registered state except the
    // strobes, so doOut/dbus never reach an output combinationally.
    always_comb begin
        q.out_valid = (count_q != '0);
        q.full      = (count_q == FULL_COUNT);
        q.count     = count_q;
        q.overflow  = overflow_q;
        q.out_data  = mem[rd_ptr];
        rd          = q.out_valid & q.out_ready;
        wr_ok       = q.doOut & (~q.full | rd);
        drop        = q.doOut & ~wr_ok;
    end

    // Byte storage write port.
    // NOTE: the storage array has no reset; stale bytes are never visible
    // because out_valid gates them, and leaving it unreset keeps it a plain RAM.
    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr] <= q.dbus;
    end

    // Pointers, occupancy and overflow flag.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
            if (rd)    rd_ptr <= rd_ptr + 1'b1;
            case ({wr_ok, rd})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            if (drop) overflow_q <= 1'b1;
        end
    end

`ifdef OUTQ_DROPCNT_EN
    logic [7:0] drop_count_q;

    // Saturating count of dropped writes, cleared only by reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            drop_count_q <= '0;
        end else if (drop && drop_count_q != 8'hFF) begin
            drop_count_q <= drop_count_q + 1'b1;
        end
    end

    assign q.drop_count = drop_count_q;
`endif
endmodule

// File: tb/tb_out_queue.sv
// Self-checking bench for out_queue: directed scenarios followed by random
// traffic, all compared against a queue-based reference model.
module tb_out_queue;
    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    always #5 clk = ~clk;

    out_queue_if #(.AW(AW)) bus ();

    out_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .q     (bus)
    );

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] mq [$];
    bit         m_ovf   = 1'b0;
    int         m_drops = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_state(input string tag);
        check({tag, ".count"}, 32'(bus.count), 32'(mq.size()));
        check({tag, ".valid"}, 32'(bus.out_valid), 32'(mq.size() != 0));
        check({tag, ".full"}, 32'(bus.full), 32'(mq.size() == DEPTH));
        check({tag, ".ovf"}, 32'(bus.overflow), 32'(m_ovf));
        if (mq.size() != 0) check({tag, ".data"}, 32'(bus.out_data), 32'(mq[0]));
`ifdef OUTQ_DROPCNT_EN
        check({tag, ".drops"}, 32'(bus.drop_count), 32'(m_drops));
`endif
    endtask

    // One clock cycle: drive inputs, advance the model, check after the edge.
    task automatic step(input string tag, input bit d, input logic [7:0] b, input bit r);
        bit rd, wr;
        bus.doOut     = d;
        bus.dbus      = b;
        bus.out_ready = r;
        rd = (mq.size() != 0) && r;
        wr = d && ((mq.size() < DEPTH) || rd);
        @(posedge clk);
        #1;
        if (rd) void'(mq.pop_front());
        if (wr) mq.push_back(b);
        else if (d) begin
            m_ovf = 1'b1;
            if (m_drops < 255) m_drops++;
        end
        bus.doOut     = 1'b0;
        bus.out_ready = 1'b0;
        check_state(tag);
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b0;
        #1;
        mq.delete();
        m_ovf   = 1'b0;
        m_drops = 0;
        check_state(tag);
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        bus.doOut     = 1'b0;
        bus.dbus      = 8'h00;
        bus.out_ready = 1'b0;
        #2;
        check_state("por");
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Reset mid-stream.
        step("rs_w0", 1, 8'h11, 0);
        step("rs_w1", 1, 8'h22, 0);
        do_reset("rs_clr");
        step("rs_w2", 1, 8'h33, 0);
        check("rs_head", 32'(bus.out_data), 32'h33);
        step("rs_rd", 0, 8'h00, 1);

        // Ordered fill then drain.
        for (int i = 0; i < 4; i++) step("fill", 1, 8'hA1 + 8'(i), 0);
        check("fill_full", 32'(bus.full), 32'd1);
        for (int i = 0; i < 4; i++) begin
            check("drain_ord", 32'(bus.out_data), 32'hA1 + i);
            step("drain", 0, 8'h00, 1);
        end
        check("drain_empty", 32'(bus.out_valid), 32'd0);

        // Latency: visible after write edge, consumed on the next.
        step("lat_w", 1, 8'h5C, 0);
        check("lat_data", 32'(bus.out_data), 32'h5C);
        step("lat_r", 0, 8'h00, 1);
        check("lat_gone", 32'(bus.out_valid), 32'd0);

        // Empty with simultaneous write and ready.
        step("emp_wr", 1, 8'h77, 1);
        step("emp_rd", 0, 8'h00, 1);

        // Full with simultaneous write and read.
        for (int i = 0; i < 4; i++) step("fs_fill", 1, 8'hB0 + 8'(i), 0);
        step("fs_wr", 1, 8'hB4, 1);
        check("fs_count", 32'(bus.count), 32'd4);
        for (int i = 1; i <= 4; i++) begin
            check("fs_ord", 32'(bus.out_data), 32'hB0 + i);
            step("fs_drain", 0, 8'h00, 1);
        end

        // Overflow and saturating drop counter.
        for (int i = 0; i < 4; i++) step("ov_fill", 1, 8'hC0 + 8'(i), 0);
        for (int i = 0; i < 3; i++) step("ov_drop", 1, 8'hEE, 0);
        check("ov_flag", 32'(bus.overflow), 32'd1);
`ifdef OUTQ_DROPCNT_EN
        check("ov_drop3", 32'(bus.drop_count), 32'd3);
`endif
        for (int i = 0; i < 300; i++) step("ov_sat", 1, 8'hEE, 0);
`ifdef OUTQ_DROPCNT_EN
        check("ov_satff", 32'(bus.drop_count), 32'hFF);
`endif
        for (int i = 0; i < 4; i++) begin
            check("ov_keep", 32'(bus.out_data), 32'hC0 + i);
            step("ov_drain", 0, 8'h00, 1);
        end
        step("ov_idle_rdy", 0, 8'h00, 1);
        check("ov_sticky", 32'(bus.overflow), 32'd1);
        do_reset("ov_clr");

        // Wrap-around with single write/read pairs.
        for (int i = 0; i < 10; i++) begin
            step("wr_w", 1, 8'(i), 0);
            check("wr_data", 32'(bus.out_data), 32'(i));
            step("wr_r", 0, 8'h00, 1);
        end

        // Random traffic with varying read bias.
        for (int i = 0; i < 3000; i++) begin
            int bias;
            bias = (i / 500) % 3;
            step("rnd", 1'($urandom_range(0, 1)), 8'($urandom()),
                 ($urandom_range(0, 3) < bias + 1));
            if (i == 1700) do_reset("rnd_rst");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
